// File: rtl/mips_feed_pkg.sv
// Shared types and helpers for the MIPS instruction feeder.
package mips_feed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOADED,
        ST_RUN,
        ST_HALT
    } feed_state_e;

    localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD_DEF = 32'h0000_000D;

    // Word index of a byte PC; a PC below base wraps to a huge index.
    function automatic logic [31:0] pc_to_idx(input logic [31:0] pc, input logic [31:0] base);
        return (pc - base) >> 2;
    endfunction

endpackage

// File: rtl/mips_prog_mem.sv
// Program store: one synchronous write port, one asynchronous read port, no reset.
module mips_prog_mem #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mips_inst_feeder.sv
// Loads a program over a valid/ready stream and feeds registered instructions to the core.
//
// state     | meaning
// ST_IDLE   | no program; waiting for the first load beat
// ST_LOAD   | accepting program beats
// ST_LOADED | program complete; waiting for start
// ST_RUN    | fetching mem[pc_next] every cycle
// ST_HALT   | stopped (end, break or misaligned PC); driving NOP
module mips_inst_feeder
    import mips_feed_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          ADDR_W    = $clog2(DEPTH),
    parameter logic [31:0] PC_BASE   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    input  logic              start,
    input  logic              clr,
    input  logic [31:0]       pc_next,
    input  logic [31:0]       pc_current,
    output logic [31:0]       extInst,
    output logic              running,
    output logic              halted,
    output logic              err_misalign,
    output logic [ADDR_W:0]   load_count,
    output logic [31:0]       inst_count
);

    localparam logic [ADDR_W:0] LC_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LC_LAST = (ADDR_W+1)'(DEPTH - 1);

    feed_state_e       r_state, w_state_nxt;
    logic [ADDR_W:0]   r_load_count;
    logic [31:0]       r_inst, r_inst_count, r_fetch_pc;
    logic              r_err;

    logic              w_accept, w_start_ok, w_fetch, w_misalign, w_oob, w_halt_fetch;
    logic [31:0]       w_fetch_pc, w_idx, w_rdata;

    assign ld_ready   = ((r_state == ST_IDLE) || (r_state == ST_LOAD)) && (r_load_count < LC_FULL);
    assign w_accept   = ld_valid && ld_ready && !clr;
    assign w_start_ok = start && ((r_state == ST_LOADED) || (r_state == ST_HALT));
    assign w_fetch    = !clr && (w_start_ok || (r_state == ST_RUN));

    // A (re)start always begins at PC_BASE; pc_next is only followed once running.
    assign w_fetch_pc   = (r_state == ST_RUN) ? pc_next : PC_BASE;
    assign w_idx        = pc_to_idx(w_fetch_pc, PC_BASE);
    assign w_misalign   = |w_fetch_pc[1:0];
    assign w_oob        = w_idx >= 32'(r_load_count);
    assign w_halt_fetch = w_misalign || w_oob || (w_rdata == HALT_WORD);

    mips_prog_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_load_count[ADDR_W-1:0]),
        .i_wdata (ld_data),
        .i_raddr (w_idx[ADDR_W-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_accept)
                        w_state_nxt = (ld_last || (r_load_count == LC_LAST)) ? ST_LOADED : ST_LOAD;
                end
                ST_LOADED, ST_HALT: begin
                    if (start) w_state_nxt = w_halt_fetch ? ST_HALT : ST_RUN;
                end
                ST_RUN: begin
                    if (w_halt_fetch) w_state_nxt = ST_HALT;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_count <= '0;
            r_inst       <= NOP_WORD;
            r_inst_count <= '0;
            r_err        <= 1'b0;
            r_fetch_pc   <= '0;
        end else if (clr) begin
            r_load_count <= '0;
            r_inst       <= NOP_WORD;
            r_inst_count <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) r_load_count <= r_load_count + 1'b1;
            if (w_fetch) begin
                r_inst     <= w_halt_fetch ? NOP_WORD : w_rdata;
                r_fetch_pc <= w_fetch_pc;
                if (w_start_ok)
                    r_inst_count <= w_halt_fetch ? 32'd0 : 32'd1;
                else if (!w_halt_fetch)
                    r_inst_count <= r_inst_count + 32'd1;
                if (w_misalign)      r_err <= 1'b1;
                else if (w_start_ok) r_err <= 1'b0;
            end
        end
    end

    // The core's pc_current must track the PC of the instruction we are presenting.
    a_pc_track: assert property (@(posedge clk) disable iff (!rst)
        (r_state == ST_RUN) |-> (pc_current == r_fetch_pc));

    assign extInst      = r_inst;
    assign running      = (r_state == ST_RUN);
    assign halted       = (r_state == ST_HALT);
    assign err_misalign = r_err;
    assign load_count   = r_load_count;
    assign inst_count   = r_inst_count;

endmodule

// File: doc/mips_inst_feeder.md
Name: mips_inst_feeder

Overview:
Upstream stage of the single-cycle MIPS core. It holds a small program memory, loaded through a valid/ready stream, and drives the core's extInst each cycle from the core's pc_next. The instruction is registered, so it lines up with pc_current on the following cycle. The block also detects end-of-program, halt instructions and misaligned PCs, and substitutes NOPs when it stops.

Parameters:
DEPTH, 256, program memory depth in 32-bit words
ADDR_W, $clog2(DEPTH), word index width
PC_BASE, 32'h0000_0000, byte address of word 0
NOP_WORD, 32'h0000_0000, word driven when not fetching
HALT_WORD, 32'h0000_000D, MIPS break; terminates the run

Ports:
clk  input  1  core clock
rst  input  1  asynchronous reset, active-low
ld_valid  input  1  load beat valid
ld_ready  output  1  feeder accepts load beat
ld_data  input  32  instruction word being loaded
ld_last  input  1  final beat of program
start  input  1  begin or restart execution at PC_BASE
clr  input  1  synchronous return to IDLE; discards program length
pc_next  input  32  core next PC
pc_current  input  32  core current PC; checker use only
extInst  output  32  instruction to core (registered)
running  output  1  state==RUN
halted  output  1  state==HALT
err_misalign  output  1  sticky; set by a fetch with pc[1:0]!=0
load_count  output  ADDR_W+1  words loaded
inst_count  output  32  instructions issued in current run

Behaviour:
- Reset (rst==0, async): state=IDLE, extInst=NOP_WORD, load_count=0, inst_count=0, err_misalign=0, running=0, halted=0. Memory contents are not reset.
- States: IDLE, LOAD, LOADED, RUN, HALT.
- ld_ready is combinational: 1 in IDLE/LOAD while load_count<DEPTH, else 0.
  - Beat accepted when ld_valid&&ld_ready: mem[load_count]<=ld_data; load_count++.
  - ld_valid in any other state is ignored.
- IDLE: the first accepted beat moves to LOAD. If that beat has ld_last=1, go directly to LOADED.
- LOAD: an accepted beat with ld_last=1 moves to LOADED. Reaching load_count==DEPTH also moves to LOADED, regardless of ld_last.
- LOADED: on start, go to RUN, extInst<=fetch(PC_BASE), inst_count<=1.
- RUN: every posedge, extInst<=fetch(pc_next) and inst_count++. extInst therefore corresponds to pc_current one cycle later (latency 1).
- fetch(pc), priority order:
  1. pc[1:0]!=0: NOP_WORD, err_misalign<=1, go to HALT.
  2. idx=(pc-PC_BASE)>>2 with idx>=load_count (includes pc<PC_BASE wrap): NOP_WORD, go to HALT.
  3. mem[idx]==HALT_WORD: NOP_WORD, go to HALT.
  4. Otherwise mem[idx].
  - inst_count does not increment on a halting fetch.
- HALT: extInst held at NOP_WORD. start re-enters RUN as from LOADED, clears err_misalign and reloads inst_count=1. Program and load_count are retained.
- clr, any state: next state IDLE, load_count=0, extInst=NOP_WORD, inst_count=0, err_misalign=0. clr wins over start and over a simultaneous load beat (beat not written).
- start in IDLE/LOAD is ignored. start in RUN is ignored.
- inst_count wraps at 2^32.
- Async reset mid-RUN forces NOP_WORD immediately, with no clock needed.

Decomposition:
- Shared package mips_feed_pkg: state enum feed_state_e; constants NOP_WORD and HALT_WORD defaults; function pc_to_idx.
- One sub-module, mips_prog_mem: DEPTH×32, one synchronous write port, one asynchronous read port, no reset. The read is registered by the parent through extInst.

Test Plan:
1. Load 4 words {0x2008_0005, 0x2009_0003, 0x0109_5020, 0x0000_000D} with ld_last on beat 4 → ld_ready falls, load_count=4. start with pc_next stepping 0,4,8,12 → extInst 0x20080005, 0x20090003, 0x01095020 on consecutive cycles, then NOP, halted=1, inst_count=3.
2. Run with pc_next=0x0000_0010 (past 4 loaded words) → extInst=0, halted=1, err_misalign=0.
3. pc_next=0x0000_0006 during RUN → extInst=0, err_misalign=1, halted=1. start → err_misalign=0, running=1, extInst=mem[0].
4. Load DEPTH beats with ld_last never asserted → ld_ready=0 after beat DEPTH, state LOADED, load_count=DEPTH. An extra ld_valid is not accepted.
5. clr and start asserted together in LOADED → state IDLE, load_count=0, running=0. clr asserted together with a load beat → beat not written.
6. Assert rst=0 asynchronously mid-RUN between clock edges → extInst=0, running=0, inst_count=0 without a clock edge.
